// File: rtl/alu_exec_if.sv
// Operand/result handshake bundle between the issue stage and the execute-stage ALU.
interface alu_exec_if #(
    parameter int WIDTH = 32
);
    localparam int SAW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_con;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SAW-1:0]   shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;

    modport master (
        output in_valid, alu_con, a, b, shamt, out_ready,
        input  in_ready, out_valid, result, zero, overflow
    );

    modport slave (
        input  in_valid, alu_con, a, b, shamt, out_ready,
        output in_ready, out_valid, result, zero, overflow
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arithmetic, iterative shifts of SHIFT_STEP bits per cycle.
// state | meaning
// IDLE  | ready for a new op
// SHIFT | shifting working register, remaining > 0
// DONE  | result valid, waiting for out_ready
module alu_exec_unit #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic      clk,
    input  logic      reset,
    alu_exec_if.slave bus
);
    localparam int SAW = $clog2(WIDTH);
    localparam logic [SAW-1:0] STEP_AMT = SAW'(SHIFT_STEP);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_overflow;
    logic [WIDTH-1:0] r_work;
    logic [SAW-1:0]   r_remain;
    logic             r_shift_left;
    logic             r_shift_arith;

    logic             w_accept;
    logic             w_is_shift;
    logic             w_var_shift;
    logic             w_left;
    logic             w_arith;
    logic [SAW-1:0]   w_amount;
    logic             w_start_shift;
    logic [SAW-1:0]   w_step;
    logic [SAW-1:0]   w_remain_next;
    logic [WIDTH-1:0] w_work_next;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_ovf;

    assign w_accept = bus.in_valid && (r_state == S_IDLE);

    always_comb begin
        w_is_shift  = 1'b0;
        w_var_shift = 1'b0;
        w_left      = 1'b0;
        w_arith     = 1'b0;
        case (bus.alu_con)
            4'b0011: begin w_is_shift = 1'b1; w_var_shift = 1'b1; w_left = 1'b1; end
            4'b0101: begin w_is_shift = 1'b1; w_var_shift = 1'b1; end
            4'b1011: begin w_is_shift = 1'b1; w_left = 1'b1; end
            4'b1100: begin w_is_shift = 1'b1; end
            4'b1101: begin w_is_shift = 1'b1; w_arith = 1'b1; end
            4'b1110: begin w_is_shift = 1'b1; w_var_shift = 1'b1; w_arith = 1'b1; end
            default: ;
        endcase
    end

    assign w_amount      = w_var_shift ? bus.a[SAW-1:0] : bus.shamt;
    assign w_start_shift = w_is_shift && (w_amount != '0);

    assign w_sum  = bus.a + bus.b;
    assign w_diff = bus.a - bus.b;

    // Shift codes fall to the default arm: a zero-amount shift simply returns b.
    always_comb begin
        w_alu_res = bus.b;
        w_alu_ovf = 1'b0;
        case (bus.alu_con)
            4'b0000: w_alu_res = bus.a & bus.b;
            4'b0001: w_alu_res = bus.a | bus.b;
            4'b0010: begin
                w_alu_res = w_sum;
                w_alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'b0100: w_alu_res = ~(bus.a | bus.b);
            4'b0110: begin
                w_alu_res = w_diff;
                w_alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'b0111: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            4'b1000: w_alu_res = w_sum;
            4'b1001: w_alu_res = w_diff;
            4'b1010: w_alu_res = bus.a ^ bus.b;
            4'b1111: w_alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            default: ;
        endcase
    end

    assign w_step        = (r_remain < STEP_AMT) ? r_remain : STEP_AMT;
    assign w_remain_next = r_remain - w_step;

    always_comb begin
        if (r_shift_left) begin
            w_work_next = r_work << w_step;
        end else if (r_shift_arith) begin
            w_work_next = $signed(r_work) >>> w_step;
        end else begin
            w_work_next = r_work >> w_step;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_start_shift ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                if (w_remain_next == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (r_state == S_IDLE);
        bus.out_valid = (r_state == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result      <= '0;
            r_zero        <= 1'b0;
            r_overflow    <= 1'b0;
            r_work        <= '0;
            r_remain      <= '0;
            r_shift_left  <= 1'b0;
            r_shift_arith <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_start_shift) begin
                            r_work        <= bus.b;
                            r_remain      <= w_amount;
                            r_shift_left  <= w_left;
                            r_shift_arith <= w_arith;
                        end else begin
                            r_result   <= w_alu_res;
                            r_zero     <= (w_alu_res == '0);
                            r_overflow <= w_alu_ovf;
                        end
                    end
                end
                S_SHIFT: begin
                    r_work   <= w_work_next;
                    r_remain <= w_remain_next;
                    if (w_remain_next == '0) begin
                        r_result   <= w_work_next;
                        r_zero     <= (w_work_next == '0);
                        r_overflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result   = r_result;
    assign bus.zero     = r_zero;
    assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed and random checks of alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;
    localparam int WIDTH = 32;
    localparam int STEP  = 1;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_exec_if #(.WIDTH(WIDTH)) bif();

    alu_exec_unit #(.WIDTH(WIDTH), .SHIFT_STEP(STEP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [3:0] con, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] sh, output logic [31:0] r, output logic ov,
                                  output int lat);
        longint sa, sb, s;
        int amt;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        s   = 0;
        ov  = 1'b0;
        amt = 0;
        r   = '0;
        case (con)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: begin s = sa + sb; r = s[31:0]; ov = (s > MAXS) || (s < MINS); end
            4'h3: begin amt = int'(a[4:0]); r = b << amt; end
            4'h4: r = ~(a | b);
            4'h5: begin amt = int'(a[4:0]); r = b >> amt; end
            4'h6: begin s = sa - sb; r = s[31:0]; ov = (s > MAXS) || (s < MINS); end
            4'h7: r = (sa < sb) ? 32'd1 : 32'd0;
            4'h8: r = a + b;
            4'h9: r = a - b;
            4'hA: r = a ^ b;
            4'hB: begin amt = int'(sh); r = b << amt; end
            4'hC: begin amt = int'(sh); r = b >> amt; end
            4'hD: begin amt = int'(sh); r = $signed(b) >>> amt; end
            4'hE: begin amt = int'(a[4:0]); r = $signed(b) >>> amt; end
            default: r = (a < b) ? 32'd1 : 32'd0;
        endcase
        lat = (amt == 0) ? 1 : (amt + STEP - 1) / STEP + 1;
    endfunction

    task automatic run_op(input string tag, input logic [3:0] con, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input int hold);
        logic [31:0] er;
        logic        eo;
        int          el;
        int          cyc;
        model(con, a, b, sh, er, eo, el);
        check({tag, " in_ready idle"}, 32'(bif.in_ready), 32'd1);
        bif.alu_con  = con;
        bif.a        = a;
        bif.b        = b;
        bif.shamt    = sh;
        bif.in_valid = 1'b1;
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        bif.a        = $urandom;
        bif.b        = $urandom;
        bif.shamt    = 5'($urandom);
        bif.alu_con  = 4'($urandom);
        check({tag, " in_ready busy"}, 32'(bif.in_ready), 32'd0);
        cyc = 1;
        while (bif.out_valid !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'(el));
        check({tag, " result"}, bif.result, er);
        check({tag, " zero"}, 32'(bif.zero), 32'(er == 32'd0));
        check({tag, " overflow"}, 32'(bif.overflow), 32'(eo));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, " held result"}, bif.result, er);
            check({tag, " held flags"}, {30'd0, bif.zero, bif.overflow}, {30'd0, er == 32'd0, eo});
            check({tag, " held valid/ready"}, {30'd0, bif.out_valid, bif.in_ready}, 32'b10);
        end
        bif.out_ready = 1'b1;
        @(posedge clk); #1;
        bif.out_ready = 1'b0;
        check({tag, " released valid/ready"}, {30'd0, bif.out_valid, bif.in_ready}, 32'b01);
    endtask

    initial begin
        reset         = 1'b1;
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b0;
        bif.alu_con   = 4'h0;
        bif.a         = '0;
        bif.b         = '0;
        bif.shamt     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 32'(bif.in_ready), 32'd1);
        check("reset out_valid", 32'(bif.out_valid), 32'd0);
        check("reset result", bif.result, 32'd0);
        check("reset flags", {30'd0, bif.zero, bif.overflow}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op("add ovf", 4'h2, 32'h7FFF_FFFF, 32'h1, 5'd0, 0);
        run_op("addu", 4'h8, 32'h7FFF_FFFF, 32'h1, 5'd0, 0);
        run_op("sub zero", 4'h6, 32'd5, 32'd5, 5'd0, 0);
        run_op("sub ovf", 4'h6, 32'h8000_0000, 32'h1, 5'd0, 0);
        run_op("slt", 4'h7, 32'hFFFF_FFFF, 32'h1, 5'd0, 0);
        run_op("sltu", 4'hF, 32'hFFFF_FFFF, 32'h1, 5'd0, 0);
        run_op("sra 4", 4'hD, 32'h0, 32'h8000_0000, 5'd4, 0);
        run_op("srav 4", 4'hE, 32'h24, 32'h8000_0000, 5'd0, 0);
        run_op("sllv 0", 4'h3, 32'h0, 32'h1234, 5'd9, 0);
        run_op("backpressure", 4'hA, 32'hF0F0_1234, 32'h0FF0_0034, 5'd0, 5);
        run_op("sll 31", 4'hB, 32'h0, 32'h1, 5'd31, 0);

        // Reset while a 20-bit shift has 10 steps remaining.
        bif.alu_con  = 4'hB;
        bif.b        = 32'h1;
        bif.shamt    = 5'd20;
        bif.in_valid = 1'b1;
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid-shift busy", 32'(bif.in_ready), 32'd0);
        reset = 1'b1;
        #1;
        check("async reset valid/ready", {30'd0, bif.out_valid, bif.in_ready}, 32'b01);
        check("async reset result", bif.result, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_op("after reset srl", 4'hC, 32'h0, 32'hDEAD_BEEF, 5'd7, 0);

        for (int n = 0; n < 60; n++) begin
            run_op("random", 4'($urandom), $urandom, $urandom, 5'($urandom), int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
